// File: rtl/sdram_write_buffer.sv
// Posted-write FIFO feeding the SDRAM arbiter's single-word write port.
// Optional store-to-load forwarding lookup enabled by defining WRITE_BUF_FWD_EN.
module sdram_write_buffer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  output logic                     writeReq,
  output logic [ADDR_W-1:0]        sl_addr,
  output logic [DATA_W-1:0]        writeData,
  input  logic                     doneWrite,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_underflow,
  input  logic [ADDR_W-1:0]        lk_addr,
  output logic                     lk_hit,
  output logic [DATA_W-1:0]        lk_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [ADDR_W-1:0] r_addr_mem [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_err_underflow;

  logic w_not_empty;
  logic w_push;
  logic w_pop;

  // Both flags come from registered count only; doneWrite never reaches wr_ready.
  assign w_not_empty = (r_count != '0);
  assign wr_ready    = (r_count != FullCount);
  assign w_push      = wr_valid && wr_ready;
  assign w_pop       = doneWrite && w_not_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (doneWrite && !w_not_empty) begin
        r_err_underflow <= 1'b1;
      end
    end
  end

  // Storage is not reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[r_wr_ptr] <= wr_addr;
      r_data_mem[r_wr_ptr] <= wr_data;
    end
  end

  assign writeReq      = w_not_empty;
  assign empty         = !w_not_empty;
  assign count         = r_count;
  assign err_underflow = r_err_underflow;
  assign sl_addr       = w_not_empty ? r_addr_mem[r_rd_ptr] : '0;
  assign writeData     = w_not_empty ? r_data_mem[r_rd_ptr] : '0;

`ifdef WRITE_BUF_FWD_EN
  // Scan oldest to youngest so the last match (youngest write) wins.
  always_comb begin
    logic [PW-1:0] w_idx;
    lk_hit  = 1'b0;
    lk_data = '0;
    w_idx   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_idx = r_rd_ptr + PW'(i);
      if ((CW'(i) < r_count) && (r_addr_mem[w_idx] == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = r_data_mem[w_idx];
      end
    end
  end
`else
  logic w_unused_lk_addr;
  assign w_unused_lk_addr = ^lk_addr;
  assign lk_hit  = 1'b0;
  assign lk_data = '0;
`endif

endmodule

// File: tb/tb_sdram_write_buffer.sv
// Scoreboard bench for sdram_write_buffer; forwarding checks run when WRITE_BUF_FWD_EN is defined.
module tb_sdram_write_buffer;

  localparam int DEPTH = 8;
  localparam int AW    = 25;
  localparam int DW    = 32;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          writeReq;
  logic [AW-1:0] sl_addr;
  logic [DW-1:0] writeData;
  logic          doneWrite;
  logic          empty;
  logic [CW-1:0] count;
  logic          err_underflow;
  logic [AW-1:0] lk_addr;
  logic          lk_hit;
  logic [DW-1:0] lk_data;

  sdram_write_buffer #(
    .DEPTH (DEPTH),
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .writeReq     (writeReq),
    .sl_addr      (sl_addr),
    .writeData    (writeData),
    .doneWrite    (doneWrite),
    .empty        (empty),
    .count        (count),
    .err_underflow(err_underflow),
    .lk_addr      (lk_addr),
    .lk_hit       (lk_hit),
    .lk_data      (lk_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic m_err    = 1'b0;

  // Advance one clock, updating the reference queue from the inputs seen at the edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      sb.delete();
      m_err = 1'b0;
    end else begin
      if (doneWrite && sb.size() == 0) m_err = 1'b1;
      if (doneWrite && sb.size() != 0) void'(sb.pop_front());
      // Full check uses size before this edge's pop: a freed slot is not reusable same cycle.
      if (wr_valid && (sb.size() + ((doneWrite && sb.size() != 0) ? 1 : 0)) < DEPTH)
        sb.push_back('{a: wr_addr, d: wr_data});
    end
    #1;
    wr_valid  = 1'b0;
    doneWrite = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; doneWrite = 1'b0; wr_addr = '0; wr_data = '0; lk_addr = '0;
    step(); step();
    rst = 1'b0;
    repeat (5) step();
    checks++; if (writeReq !== 1'b0) begin failures++; $display("FAIL reset_writeReq got=%b exp=0", writeReq); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_underflow); end
    checks++; if (sl_addr !== '0 || writeData !== '0) begin
      failures++; $display("FAIL reset_head got=%h/%h exp=0/0", sl_addr, writeData);
    end
    checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL reset_lk_hit got=%b exp=0", lk_hit); end
  endtask

  task automatic test_single();
    checks++; if (writeReq !== 1'b0) begin failures++; $display("FAIL single_pre_req got=%b exp=0", writeReq); end
    push(25'h10, 32'hA5A5_A5A5);
    checks++; if (writeReq !== 1'b1) begin failures++; $display("FAIL single_req got=%b exp=1", writeReq); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (sl_addr !== 25'h10 || writeData !== 32'hA5A5_A5A5 || sl_addr !== sb[0].a) begin
        failures++; $display("FAIL single_hold[%0d] got=%h/%h exp=10/a5a5a5a5", c, sl_addr, writeData);
      end
      step();
    end
    doneWrite = 1'b1;
    #1;
    checks++; if (sl_addr !== 25'h10 || writeData !== 32'hA5A5_A5A5) begin
      failures++; $display("FAIL single_done_cycle got=%h/%h exp=10/a5a5a5a5", sl_addr, writeData);
    end
    step();
    checks++; if (writeReq !== 1'b0 || count !== 4'd0) begin
      failures++; $display("FAIL single_drained got=%b/%0d exp=0/0", writeReq, count);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) push(AW'(i), DW'(32'h100 + i));
    checks++; if (count !== 4'd8 || wr_ready !== 1'b0) begin
      failures++; $display("FAIL fill_full got=%0d/%b exp=8/0", count, wr_ready);
    end
    push(25'h8, 32'h108);
    checks++; if (count !== 4'(sb.size()) || count !== 4'd8) begin
      failures++; $display("FAIL fill_drop9 got=%0d exp=8", count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (sb.size() == 0 || sl_addr !== sb[0].a || writeData !== sb[0].d || sl_addr !== AW'(i)) begin
        failures++; $display("FAIL drain_order[%0d] got=%h/%h exp=%h/%h", i, sl_addr, writeData,
                             AW'(i), DW'(32'h100 + i));
      end
      doneWrite = 1'b1;
      step();
    end
    checks++; if (empty !== 1'b1 || writeReq !== 1'b0) begin
      failures++; $display("FAIL drain_empty got=%b/%b exp=1/0", empty, writeReq);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++) push(AW'(32'h40 + i), DW'(32'h200 + i));
    wr_valid = 1'b1; wr_addr = 25'h50; wr_data = 32'h250; doneWrite = 1'b1;
    #1;
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL bb_full_ready got=%b exp=0", wr_ready); end
    step();
    checks++; if (count !== 4'd7 || count !== 4'(sb.size())) begin
      failures++; $display("FAIL bb_full_pop got=%0d exp=7", count);
    end
    push(25'h51, 32'h251);
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL bb_refill got=%0d exp=8", count); end
    while (sb.size() > 3) begin
      checks++;
      if (sl_addr !== sb[0].a || writeData !== sb[0].d) begin
        failures++; $display("FAIL bb_drain got=%h/%h exp=%h/%h", sl_addr, writeData, sb[0].a, sb[0].d);
      end
      doneWrite = 1'b1;
      step();
    end
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL bb_count3 got=%0d exp=3", count); end
    wr_valid = 1'b1; wr_addr = 25'h60; wr_data = 32'h260; doneWrite = 1'b1;
    step();
    checks++; if (count !== 4'd3 || sl_addr !== sb[0].a || writeData !== sb[0].d) begin
      failures++; $display("FAIL bb_pushpop got=%0d/%h exp=3/%h", count, sl_addr, sb[0].a);
    end
    while (sb.size() > 0) begin
      checks++;
      if (sl_addr !== sb[0].a || writeData !== sb[0].d) begin
        failures++; $display("FAIL bb_tail got=%h/%h exp=%h/%h", sl_addr, writeData, sb[0].a, sb[0].d);
      end
      doneWrite = 1'b1;
      step();
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL bb_empty got=%b exp=1", empty); end
  endtask

  task automatic test_underflow();
    doneWrite = 1'b1;
    step();
    checks++; if (count !== 4'd0 || writeReq !== 1'b0) begin
      failures++; $display("FAIL uf_count got=%0d/%b exp=0/0", count, writeReq);
    end
    repeat (3) step();
    checks++; if (err_underflow !== m_err || m_err !== 1'b1) begin
      failures++; $display("FAIL uf_sticky got=%b exp=1", err_underflow);
    end
    for (int i = 0; i < 5; i++) push(AW'(32'h70 + i), DW'(32'h300 + i));
    checks++; if (count !== 4'd5 || sl_addr !== sb[0].a || writeData !== sb[0].d) begin
      failures++; $display("FAIL uf_ptrs got=%0d/%h exp=5/%h", count, sl_addr, sb[0].a);
    end
    rst = 1'b1;
    #1;
    checks++; if (writeReq !== 1'b0 || count !== 4'd0 || err_underflow !== 1'b0) begin
      failures++; $display("FAIL rst_async got=%b/%0d/%b exp=0/0/0", writeReq, count, err_underflow);
    end
    step();
    rst = 1'b0;
    step();
    checks++; if (empty !== 1'b1 || sb.size() != 0) begin
      failures++; $display("FAIL rst_after got=%b exp=1", empty);
    end
  endtask

`ifdef WRITE_BUF_FWD_EN
  task automatic test_forward();
    push(25'h20, 32'h1);
    push(25'h30, 32'h2);
    lk_addr = 25'h20; wr_valid = 1'b1; wr_addr = 25'h20; wr_data = 32'h3;
    #1;
    checks++; if (lk_hit !== 1'b1 || lk_data !== 32'h1) begin
      failures++; $display("FAIL fwd_samecycle got=%b/%h exp=1/1", lk_hit, lk_data);
    end
    step();
    #1;
    checks++; if (lk_hit !== 1'b1 || lk_data !== 32'h3) begin
      failures++; $display("FAIL fwd_youngest got=%b/%h exp=1/3", lk_hit, lk_data);
    end
    lk_addr = 25'h40;
    #1;
    checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL fwd_miss got=%b exp=0", lk_hit); end
    lk_addr = 25'h20; doneWrite = 1'b1;
    #1;
    checks++; if (lk_hit !== 1'b1 || lk_data !== 32'h3) begin
      failures++; $display("FAIL fwd_popping got=%b/%h exp=1/3", lk_hit, lk_data);
    end
    step();
    doneWrite = 1'b1; step();
    doneWrite = 1'b1; step();
    checks++; if (lk_hit !== 1'b0 || empty !== 1'b1) begin
      failures++; $display("FAIL fwd_drained got=%b/%b exp=0/1", lk_hit, empty);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_underflow();
`ifdef WRITE_BUF_FWD_EN
    test_forward();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
